// File: rtl/rs_pkg.sv
// Shared types and constants for the RS(255,251) framing slice.
// GF(2^8) uses primitive polynomial 0x11d.
package rs_pkg;

  typedef logic [7:0] sym_t;

  localparam int NPAR = 4;

  // generator x^4 + 0f x^3 + 36 x^2 + 78 x + 40, low coefficient first
  localparam logic [NPAR*8-1:0] GEN = {8'h0f, 8'h36, 8'h78, 8'h40};

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PAR,
    FLUSH
  } state_t;

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t r;
    sym_t x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return r;
  endfunction

endpackage

// File: rtl/rsenc.sv
// Systematic 4-parity RS encoder: passes symbols while control=1,
// then shifts parity out and zero-fills while control=0.
module rsenc
  import rs_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic control,
  input  sym_t in,
  output sym_t out
);

  sym_t in_r;
  logic ctl_r;
  logic [NPAR-1:0][7:0] p;
  sym_t fb;

  assign fb  = in_r ^ p[NPAR-1];
  assign out = ctl_r ? in_r : p[NPAR-1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      in_r  <= '0;
      ctl_r <= 1'b0;
      p     <= '0;
    end else begin
      in_r  <= in;
      ctl_r <= control;
      if (ctl_r) begin
        p[0] <= gf_mul(fb, GEN[7:0]);
        for (int i = 1; i < NPAR; i++)
          p[i] <= p[i-1] ^ gf_mul(fb, GEN[8*i +: 8]);
      end else begin
        p[0] <= '0;
        for (int i = 1; i < NPAR; i++)
          p[i] <= p[i-1];
      end
    end
  end

endmodule

// File: rtl/rs_enc_framer.sv
// Framing FSM around rsenc: handshake intake, parity drain,
// abort flush and one-cycle registered codeword flags.
module rs_enc_framer
  import rs_pkg::*;
#(
  parameter int KMAX = 251
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] cfg_len,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_par,
  output logic       out_abort
);

  localparam logic [7:0] KM    = 8'(KMAX);
  localparam logic [1:0] PLAST = 2'(NPAR - 1);

  state_t     st, st_n;
  logic [7:0] mcnt, mcnt_n;
  logic [7:0] klen, klen_n;
  logic [1:0] pcnt, pcnt_n;
  logic [7:0] kin;
  logic       accept;
  logic       enc_ctl;
  sym_t       enc_in;

  assign in_ready = (st == IDLE) || (st == MSG);
  assign accept   = in_valid && in_ready;
  assign kin      = (cfg_len == 8'd0 || cfg_len > KM) ? KM : cfg_len;
  assign enc_ctl  = accept;
  assign enc_in   = accept ? in_data : 8'h00;

  rsenc u_enc (
    .clk     (clk),
    .nrst    (nrst),
    .control (enc_ctl),
    .in      (enc_in),
    .out     (out_data)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st   <= IDLE;
      mcnt <= '0;
      klen <= '0;
      pcnt <= '0;
    end else begin
      st   <= st_n;
      mcnt <= mcnt_n;
      klen <= klen_n;
      pcnt <= pcnt_n;
    end
  end

  always_comb begin
    st_n   = st;
    mcnt_n = mcnt;
    klen_n = klen;
    pcnt_n = pcnt;
    unique case (st)
      IDLE: begin
        if (accept) begin
          klen_n = kin;
          mcnt_n = 8'd1;
          pcnt_n = '0;
          st_n   = (kin == 8'd1) ? PAR : MSG;
        end
      end
      MSG: begin
        if (accept) begin
          mcnt_n = mcnt + 8'd1;
          if (mcnt == klen - 8'd1) begin
            st_n   = PAR;
            pcnt_n = '0;
          end
        end else begin
          st_n   = FLUSH;
          pcnt_n = '0;
        end
      end
      PAR, FLUSH: begin
        pcnt_n = pcnt + 2'd1;
        if (pcnt == PLAST) begin
          st_n   = IDLE;
          pcnt_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_par   <= 1'b0;
      out_abort <= 1'b0;
    end else begin
      out_valid <= accept || (st == PAR);
      out_sop   <= accept && (st == IDLE);
      out_par   <= (st == PAR);
      out_eop   <= (st == PAR) && (pcnt == PLAST);
      out_abort <= (st == MSG) && !in_valid;
    end
  end

endmodule

// File: tb/tb_rs_enc_framer.sv
// Bench for rs_enc_framer: two instances (KMAX 251 and 8) checked
// every cycle against a message-level polynomial-division model.
module tb_rs_enc_framer;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] cfg[2];
  logic [7:0] din[2];
  logic [7:0] od[2];
  logic vin[2];
  logic rdy[2];
  logic ov[2];
  logic os[2];
  logic oe[2];
  logic op[2];
  logic oa[2];

  rs_enc_framer #(.KMAX(251)) u_big (
    .clk(clk), .nrst(nrst),
    .cfg_len(cfg[0]), .in_data(din[0]),
    .in_valid(vin[0]), .in_ready(rdy[0]),
    .out_data(od[0]), .out_valid(ov[0]),
    .out_sop(os[0]), .out_eop(oe[0]),
    .out_par(op[0]), .out_abort(oa[0])
  );

  rs_enc_framer #(.KMAX(8)) u_small (
    .clk(clk), .nrst(nrst),
    .cfg_len(cfg[1]), .in_data(din[1]),
    .in_valid(vin[1]), .in_ready(rdy[1]),
    .out_data(od[1]), .out_valid(ov[1]),
    .out_sop(os[1]), .out_eop(oe[1]),
    .out_par(op[1]), .out_abort(oa[1])
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, int u,
                     logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d t=%0t got=%h want=%h",
               nm, u, $time, act, exp);
    end
  endtask

  function automatic byte unsigned gm(byte unsigned a,
                                      byte unsigned b);
    logic [8:0] x;
    byte unsigned r;
    r = 0;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11d;
    end
    return r;
  endfunction

  // remainder of m(x)*x^4 / g(x), first-emitted byte in [31:24]
  function automatic logic [31:0] rem4(input byte unsigned m[$]);
    byte unsigned c[$];
    byte unsigned g[5];
    byte unsigned f;
    int n;
    g[0] = 8'h01; g[1] = 8'h0f; g[2] = 8'h36;
    g[3] = 8'h78; g[4] = 8'h40;
    c = m;
    n = m.size();
    for (int i = 0; i < 4; i++) c.push_back(8'h00);
    for (int i = 0; i < n; i++) begin
      f = c[i];
      for (int j = 1; j <= 4; j++)
        c[i+j] = c[i+j] ^ gm(f, g[j]);
    end
    return {c[n], c[n+1], c[n+2], c[n+3]};
  endfunction

  byte unsigned mbuf[2][256];
  int mlen[2];
  int klat[2];
  int blk[2];
  bit bpar[2];
  logic [31:0] pw[2];
  bit e_v[2], e_s[2], e_e[2], e_p[2], e_a[2];
  byte unsigned e_d[2];
  int ovcnt[2], eopcnt[2], abcnt[2];

  function automatic int kmax_of(int u);
    return (u == 0) ? 251 : 8;
  endfunction

  task automatic step(int u);
    bit acc;
    int k;
    byte unsigned q[$];
    e_v[u] = 0; e_s[u] = 0; e_e[u] = 0;
    e_p[u] = 0; e_a[u] = 0;
    acc = vin[u] && (blk[u] == 0);
    if (blk[u] > 0) begin
      if (bpar[u]) begin
        e_v[u] = 1;
        e_p[u] = 1;
        e_d[u] = pw[u][8*(blk[u]-1) +: 8];
        e_e[u] = (blk[u] == 1);
      end
      blk[u]--;
    end else if (mlen[u] > 0 && !vin[u]) begin
      e_a[u] = 1;
      blk[u] = 4;
      bpar[u] = 0;
      mlen[u] = 0;
    end else if (acc) begin
      if (mlen[u] == 0) begin
        k = int'(cfg[u]);
        if (k == 0 || k > kmax_of(u)) k = kmax_of(u);
        klat[u] = k;
        e_s[u] = 1;
      end
      mbuf[u][mlen[u]] = din[u];
      mlen[u]++;
      e_v[u] = 1;
      e_d[u] = din[u];
      if (mlen[u] == klat[u]) begin
        q = {};
        for (int i = 0; i < mlen[u]; i++) q.push_back(mbuf[u][i]);
        pw[u] = rem4(q);
        blk[u] = 4;
        bpar[u] = 1;
        mlen[u] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int u = 0; u < 2; u++) begin
        mlen[u] = 0; klat[u] = 0; blk[u] = 0; bpar[u] = 0;
        e_v[u] = 0; e_s[u] = 0; e_e[u] = 0;
        e_p[u] = 0; e_a[u] = 0; e_d[u] = 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) step(u);
    end
  end

  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("ready", u, 32'(rdy[u]), 32'(blk[u] == 0));
      chk("valid", u, 32'(ov[u]), 32'(e_v[u]));
      chk("sop", u, 32'(os[u]), 32'(e_s[u]));
      chk("eop", u, 32'(oe[u]), 32'(e_e[u]));
      chk("par", u, 32'(op[u]), 32'(e_p[u]));
      chk("abort", u, 32'(oa[u]), 32'(e_a[u]));
      if (e_v[u]) chk("data", u, 32'(od[u]), 32'(e_d[u]));
      if (ov[u]) ovcnt[u]++;
      if (oe[u]) eopcnt[u]++;
      if (oa[u]) abcnt[u]++;
    end
  end

  task automatic send(int u, int k, input byte unsigned m[$],
                      output int stalls);
    int i;
    int guard;
    bit a;
    i = 0;
    guard = 0;
    stalls = 0;
    cfg[u] = 8'(k);
    while (i < m.size()) begin
      @(negedge clk);
      din[u] = m[i];
      vin[u] = 1'b1;
      a = rdy[u];
      @(posedge clk);
      if (a) i++;
      else stalls++;
      guard++;
      if (guard > 2000) begin
        chk("send_timeout", u, 32'(i), 32'(m.size()));
        break;
      end
    end
    @(negedge clk);
    vin[u] = 1'b0;
    din[u] = 8'h00;
  endtask

  task automatic chk_zero(int u);
    chk("rst_valid", u, 32'(ov[u]), 0);
    chk("rst_sop", u, 32'(os[u]), 0);
    chk("rst_eop", u, 32'(oe[u]), 0);
    chk("rst_par", u, 32'(op[u]), 0);
    chk("rst_abort", u, 32'(oa[u]), 0);
    chk("rst_data", u, 32'(od[u]), 0);
    chk("rst_ready", u, 32'(rdy[u]), 1);
  endtask

  initial begin
    byte unsigned q[$];
    int st;
    int b0, b1;
    logic [7:0] pick[8];
    pick[0] = 0; pick[1] = 1; pick[2] = 2; pick[3] = 3;
    pick[4] = 5; pick[5] = 8; pick[6] = 9; pick[7] = 200;
    for (int u = 0; u < 2; u++) begin
      cfg[u] = 0; din[u] = 0; vin[u] = 0;
      ovcnt[u] = 0; eopcnt[u] = 0; abcnt[u] = 0;
    end

    q = {}; q.push_back(8'h01);
    chk("pin_01", 0, rem4(q), 32'h0f367840);
    q = {}; q.push_back(8'h02);
    chk("pin_02", 0, rem4(q), 32'h1e6cf080);
    q = {}; repeat (3) q.push_back(8'h00);
    chk("pin_zero", 0, rem4(q), 32'h0);

    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    b0 = ovcnt[0]; b1 = eopcnt[0];
    q = {}; repeat (251) q.push_back(8'h00);
    send(0, 0, q, st);
    repeat (10) @(negedge clk);
    chk("big_len", 0, 32'(ovcnt[0] - b0), 255);
    chk("big_eop", 0, 32'(eopcnt[0] - b1), 1);

    q = {}; q.push_back(8'h01); q.push_back(8'h02);
    q.push_back(8'h03);
    send(1, 3, q, st);
    repeat (8) @(negedge clk);

    q = {};
    for (int i = 1; i <= 6; i++) q.push_back(8'(i * 17));
    send(1, 3, q, st);
    chk("b2b_stall", 1, 32'(st), 4);
    repeat (8) @(negedge clk);

    b0 = abcnt[1];
    q = {}; q.push_back(8'h11); q.push_back(8'h22);
    send(1, 4, q, st);
    repeat (8) @(negedge clk);
    chk("abort_cnt", 1, 32'(abcnt[1] - b0), 1);
    q = {}; q.push_back(8'h01); q.push_back(8'h02);
    q.push_back(8'h03); q.push_back(8'h04);
    send(1, 4, q, st);
    repeat (8) @(negedge clk);

    q = {}; q.push_back(8'h09); q.push_back(8'h08);
    q.push_back(8'h07);
    send(1, 3, q, st);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 chk_zero(1);
    @(negedge clk);
    nrst = 1'b1;
    q = {}; q.push_back(8'haa);
    send(1, 1, q, st);
    repeat (8) @(negedge clk);

    b0 = ovcnt[1];
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    send(1, 200, q, st);
    repeat (8) @(negedge clk);
    chk("clamp_len", 1, 32'(ovcnt[1] - b0), 12);

    repeat (3000) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        vin[u] = ($urandom_range(0, 15) != 0);
        din[u] = 8'($urandom);
        if ($urandom_range(0, 30) == 0)
          cfg[u] = pick[$urandom_range(0, 7)];
      end
    end
    @(negedge clk);
    vin[0] = 0;
    vin[1] = 0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
